poly1305_pblock_seq: RTL and testbench
======================================

// Module: poly1305_pblock_seq
// PURPOSE
//  Initiator side of the p-block interface. Packs a 32-bit little-endian message word stream
//  into 130-bit Poly1305 blocks (c0..c4), adds hibit/0x01 padding, and issues one start per
//  block to a poly1305_pblock. Holds accumulator h across blocks and feeds each h_new back.
//  Sits between the message FIFO and the p-block; the final reduction stage reads h once done.
// PARAMETERS
//  none (widths fixed by the Poly1305 limb format: 4x32 message limbs, 5x32 accumulator limbs)
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  init           in   1   pulse: clear h0..h4 to 0; honoured only in IDLE
//  msg_valid      in   1   message word valid
//  msg_ready      out  1   word accepted when msg_valid & msg_ready
//  msg_data       in   32  message word, byte 0 in [7:0]
//  msg_last       in   1   final word of message
//  msg_last_len   in   3   valid bytes in final word, 1..4; ignored unless msg_last
//  busy           out  1   high from first accepted word until done
//  done           out  1   1-cycle pulse: last block's h_new captured
//  h0..h4         out  32  accumulator limbs (h registers)
//  pb_start       out  1   1-cycle start to p-block
//  pb_ready       in   1   p-block ready
//  pb_h0..pb_h4   out  32  h to p-block (= h regs)
//  pb_c0..pb_c4   out  32  packed block to p-block
//  pb_h0_new..pb_h4_new in 32 p-block result
// BEHAVIOUR
//  Reset: all h/c regs 0, word_ctr 0, msg_ready 0, busy 0, done 0, pb_start 0, state IDLE.
//  FSM: IDLE -> COLLECT (msg_valid) -> START -> WAIT -> COLLECT | DONE -> IDLE.
//  IDLE: msg_ready=0; init clears h (init has priority; first word accepted next cycle).
//  COLLECT: msg_ready=1; word k (k=word_ctr 0..3) written to c_k, word_ctr++.
//   - 4th word, not last: c4=1, -> START.
//   - last word with n=4*k+msg_last_len bytes in block:
//     n==16: c4=1; n<16: byte n of c0..c3 = 0x01, bytes >n = 0, c4=0; -> START, final flag set.
//   - unused c words cleared when the block is opened (word_ctr==0 entry).
//  START: pb_start=1 one cycle; msg_ready=0.
//  WAIT: pb_h*/pb_c* held constant until pb_ready=1 (p-block samples them every cycle).
//   pb_ready is 0 on the cycle after pb_start. On pb_ready=1: h <= pb_h*_new,
//   word_ctr <= 0; final ? DONE : COLLECT.
//  DONE: done=1 one cycle, busy->0, -> IDLE. h stays until init.
//  Message of exactly 16m bytes: m blocks, no extra pad block. Latency per block: 4 accept
//   cycles + 1 START + p-block latency + 1 capture.
//  msg_valid low in COLLECT: stall, partial block held. init outside IDLE: ignored.
//  reset_n low mid-WAIT: FSM to IDLE at once; p-block is reset by the same reset_n.
// STRUCTURE
//  Shared package poly1305_pkg: FSM state encodings, POLY_PAD_BYTE=8'h01, HIBIT=32'h1.
//  Sub-module poly1305_pad (combinational: word_ctr, last_len, data -> padded c0..c4).
//  Top instantiates poly1305_pad. Bench pairs it with poly1305_pblock plus a bigint model.
// TESTING
//  3-byte msg 0x41,0x42,0x43 (last_len=3) -> one pb_start, pb_c0=32'h01434241, c1..c4=0, one done.
//  16-byte msg words 0x03020100..0x0f0e0d0c -> one block, pb_c4=1, no 2nd start.
//  17-byte msg -> 2 starts; block 2 pb_c0=32'h00000110, pb_c4=0; h equals model after each block.
//  RFC 8439 2.5.2 vector, 34 bytes, r clamped -> 3 blocks; h matches bigint model; tag=a8061dc1...27a9 after final stage.
//  msg_valid gaps of 1-3 cycles + init during WAIT -> h and c unchanged by gaps, init ignored.
//  reset_n low 2 cycles after pb_start -> state IDLE, busy=0, h=0; next msg processes clean.

Source files
------------

// File: rtl/poly1305_pblock_seq_pkg.sv
// Shared types and constants for the Poly1305 p-block sequencer.
// FSM state encoding, pad byte and 2^128 hibit limb value.
package poly1305_pblock_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0]  POLY_PAD_BYTE = 8'h01;
    localparam logic [31:0] HIBIT         = 32'h1;

endpackage

// File: rtl/poly1305_pblock_seq_if.sv
// Bus bundle between message source, sequencer and p-block.
// master = sequencer view, slave = message source / p-block view.
interface poly1305_pblock_seq_if;

    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_data;
    logic        msg_last;
    logic [2:0]  msg_last_len;

    logic        pb_start;
    logic        pb_ready;
    logic [31:0] pb_h0, pb_h1, pb_h2, pb_h3, pb_h4;
    logic [31:0] pb_c0, pb_c1, pb_c2, pb_c3, pb_c4;
    logic [31:0] pb_h0_new, pb_h1_new, pb_h2_new;
    logic [31:0] pb_h3_new, pb_h4_new;

    modport master (
        input  msg_valid, msg_data, msg_last, msg_last_len,
        input  pb_ready,
        input  pb_h0_new, pb_h1_new, pb_h2_new,
        input  pb_h3_new, pb_h4_new,
        output msg_ready, pb_start,
        output pb_h0, pb_h1, pb_h2, pb_h3, pb_h4,
        output pb_c0, pb_c1, pb_c2, pb_c3, pb_c4
    );

    modport slave (
        output msg_valid, msg_data, msg_last, msg_last_len,
        output pb_ready,
        output pb_h0_new, pb_h1_new, pb_h2_new,
        output pb_h3_new, pb_h4_new,
        input  msg_ready, pb_start,
        input  pb_h0, pb_h1, pb_h2, pb_h3, pb_h4,
        input  pb_c0, pb_c1, pb_c2, pb_c3, pb_c4
    );

endinterface

// File: rtl/poly1305_pblock_seq_pad.sv
// Combinational block packer: places word i_word_ctr, applies 0x01 pad.
// In: word_ctr, last, last_len, data, current c0..c3. Out: next c0..c4.
module poly1305_pblock_seq_pad
    import poly1305_pblock_seq_pkg::*;
(
    input  logic [1:0]  i_word_ctr,
    input  logic        i_last,
    input  logic [2:0]  i_last_len,
    input  logic [31:0] i_data,
    input  logic [31:0] i_c0,
    input  logic [31:0] i_c1,
    input  logic [31:0] i_c2,
    input  logic [31:0] i_c3,
    output logic [31:0] o_c0,
    output logic [31:0] o_c1,
    output logic [31:0] o_c2,
    output logic [31:0] o_c3,
    output logic [31:0] o_c4
);

    logic        w_full;
    logic [31:0] w_word;
    logic [31:0] w_pad;

    // Any length other than 1..3 fills the whole word.
    assign w_full = !i_last
                 || ((i_last_len != 3'd1)
                  && (i_last_len != 3'd2)
                  && (i_last_len != 3'd3));

    // A full final word pushes the pad byte into the next word.
    assign w_pad = (i_last && w_full) ? {24'h0, POLY_PAD_BYTE} : 32'h0;

    always_comb begin
        w_word = i_data;
        if (i_last) begin
            case (i_last_len)
                3'd1:    w_word = {16'h0, POLY_PAD_BYTE, i_data[7:0]};
                3'd2:    w_word = {8'h0, POLY_PAD_BYTE, i_data[15:0]};
                3'd3:    w_word = {POLY_PAD_BYTE, i_data[23:0]};
                default: w_word = i_data;
            endcase
        end
    end

    // Words above the current one are cleared, so a new block
    // never carries stale bytes from the previous one.
    always_comb begin
        o_c0 = i_c0;
        o_c1 = i_c1;
        o_c2 = i_c2;
        o_c3 = i_c3;
        o_c4 = 32'h0;
        unique case (i_word_ctr)
            2'd0: begin
                o_c0 = w_word;
                o_c1 = w_pad;
                o_c2 = 32'h0;
                o_c3 = 32'h0;
            end
            2'd1: begin
                o_c1 = w_word;
                o_c2 = w_pad;
                o_c3 = 32'h0;
            end
            2'd2: begin
                o_c2 = w_word;
                o_c3 = w_pad;
            end
            2'd3: begin
                o_c3 = w_word;
                o_c4 = w_full ? HIBIT : 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/poly1305_pblock_seq.sv
// Packs 32-bit message words into Poly1305 blocks, drives the p-block.
// Ports: clk, reset_n, init, busy, done, h0..h4, bus (msg + pb side).
module poly1305_pblock_seq
    import poly1305_pblock_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    output logic        busy,
    output logic        done,
    output logic [31:0] h0,
    output logic [31:0] h1,
    output logic [31:0] h2,
    output logic [31:0] h3,
    output logic [31:0] h4,
    poly1305_pblock_seq_if.master bus
);

    state_t      r_state;
    logic [1:0]  r_word_ctr;
    logic        r_final;
    logic        r_busy;
    logic        r_done;
    logic        r_start;
    logic        r_msg_ready;
    logic [31:0] r_c0, r_c1, r_c2, r_c3, r_c4;
    logic [31:0] r_h0, r_h1, r_h2, r_h3, r_h4;

    logic        w_accept;
    logic [31:0] w_c0, w_c1, w_c2, w_c3, w_c4;

    assign w_accept = (r_state == S_COLLECT)
                   && r_msg_ready
                   && bus.msg_valid;

    poly1305_pblock_seq_pad u_pad (
        .i_word_ctr (r_word_ctr),
        .i_last     (bus.msg_last),
        .i_last_len (bus.msg_last_len),
        .i_data     (bus.msg_data),
        .i_c0       (r_c0),
        .i_c1       (r_c1),
        .i_c2       (r_c2),
        .i_c3       (r_c3),
        .o_c0       (w_c0),
        .o_c1       (w_c1),
        .o_c2       (w_c2),
        .o_c3       (w_c3),
        .o_c4       (w_c4)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_word_ctr  <= 2'd0;
            r_final     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start     <= 1'b0;
            r_msg_ready <= 1'b0;
            r_c0 <= '0; r_c1 <= '0; r_c2 <= '0;
            r_c3 <= '0; r_c4 <= '0;
            r_h0 <= '0; r_h1 <= '0; r_h2 <= '0;
            r_h3 <= '0; r_h4 <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (init) begin
                        r_h0 <= '0; r_h1 <= '0; r_h2 <= '0;
                        r_h3 <= '0; r_h4 <= '0;
                    end else if (bus.msg_valid) begin
                        r_word_ctr  <= 2'd0;
                        r_msg_ready <= 1'b1;
                        r_state     <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_busy     <= 1'b1;
                        r_c0       <= w_c0;
                        r_c1       <= w_c1;
                        r_c2       <= w_c2;
                        r_c3       <= w_c3;
                        r_c4       <= w_c4;
                        r_word_ctr <= r_word_ctr + 2'd1;
                        if (bus.msg_last || (r_word_ctr == 2'd3)) begin
                            r_final     <= bus.msg_last;
                            r_msg_ready <= 1'b0;
                            r_start     <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // pb_h*/pb_c* come straight from the h/c registers,
                    // which stay frozen here until the result lands.
                    if (bus.pb_ready) begin
                        r_h0       <= bus.pb_h0_new;
                        r_h1       <= bus.pb_h1_new;
                        r_h2       <= bus.pb_h2_new;
                        r_h3       <= bus.pb_h3_new;
                        r_h4       <= bus.pb_h4_new;
                        r_word_ctr <= 2'd0;
                        if (r_final) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_msg_ready <= 1'b1;
                            r_state     <= S_COLLECT;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_final <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign h0 = r_h0;
    assign h1 = r_h1;
    assign h2 = r_h2;
    assign h3 = r_h3;
    assign h4 = r_h4;

    assign bus.msg_ready = r_msg_ready;
    assign bus.pb_start  = r_start;
    assign bus.pb_h0 = r_h0;
    assign bus.pb_h1 = r_h1;
    assign bus.pb_h2 = r_h2;
    assign bus.pb_h3 = r_h3;
    assign bus.pb_h4 = r_h4;
    assign bus.pb_c0 = r_c0;
    assign bus.pb_c1 = r_c1;
    assign bus.pb_c2 = r_c2;
    assign bus.pb_c3 = r_c3;
    assign bus.pb_c4 = r_c4;

endmodule

// File: tb/tb_poly1305_pblock_seq.sv
// Scoreboard bench for poly1305_pblock_seq with a behavioural p-block.
// Expected blocks/h are queued by stimulus, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_poly1305_pblock_seq;

    localparam int PB_LAT = 4;
    localparam logic [127:0] R_KEY = 128'h0806d5400e52447c036d555408bed685;
    localparam logic [127:0] S_KEY = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] TAG   = 128'ha927010caf8b2bc2c6365130c11d06a8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init;
    logic        busy;
    logic        done;
    logic [31:0] h0, h1, h2, h3, h4;

    poly1305_pblock_seq_if bus ();

    poly1305_pblock_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .busy    (busy),
        .done    (done),
        .h0      (h0),
        .h1      (h1),
        .h2      (h2),
        .h3      (h3),
        .h4      (h4),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [159:0] c;
        logic [159:0] h;
    } blk_t;

    blk_t         exp_blk_q [$];
    logic [159:0] exp_done_q [$];
    logic [159:0] m_h;
    logic [31:0]  words [$];

    logic [159:0] w_h, w_pb_h, w_pb_c;
    assign w_h    = {h4, h3, h2, h1, h0};
    assign w_pb_h = {bus.pb_h4, bus.pb_h3, bus.pb_h2, bus.pb_h1, bus.pb_h0};
    assign w_pb_c = {bus.pb_c4, bus.pb_c3, bus.pb_c2, bus.pb_c1, bus.pb_c0};

    // (h + c) * r mod 2^130-5, fully reduced
    function automatic logic [159:0] poly_step(input logic [159:0] h,
                                               input logic [159:0] c,
                                               input logic [127:0] r);
        logic [319:0] acc;
        logic [319:0] p;
        p   = (320'd1 << 130) - 320'd5;
        acc = (320'(h) + 320'(c)) * 320'(r);
        acc = acc % p;
        return acc[159:0];
    endfunction

    function automatic logic [159:0] mk(input logic [31:0] c4, input logic [31:0] c3,
                                        input logic [31:0] c2, input logic [31:0] c1,
                                        input logic [31:0] c0);
        return {c4, c3, c2, c1, c0};
    endfunction

    task automatic check(input string name, input logic [159:0] act,
                         input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // behavioural p-block
    logic [2:0]   pb_cnt;
    logic [159:0] pb_res;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.pb_ready <= 1'b1;
            pb_cnt       <= 3'd0;
            pb_res       <= '0;
        end else if (bus.pb_start) begin
            bus.pb_ready <= 1'b0;
            pb_cnt       <= 3'(PB_LAT);
        end else if (!bus.pb_ready) begin
            if (pb_cnt == 3'd1) begin
                bus.pb_ready <= 1'b1;
                pb_res       <= poly_step(w_pb_h, w_pb_c, R_KEY);
            end
            pb_cnt <= pb_cnt - 3'd1;
        end
    end
    assign {bus.pb_h4_new, bus.pb_h3_new, bus.pb_h2_new,
            bus.pb_h1_new, bus.pb_h0_new} = pb_res;

    // monitor
    blk_t         mon_b;
    logic [159:0] mon_h;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.pb_start) begin
                if (exp_blk_q.size() == 0) begin
                    check("extra_start", 160'(bus.pb_start), 160'd0);
                end else begin
                    mon_b = exp_blk_q.pop_front();
                    check("pb_c", w_pb_c, mon_b.c);
                    check("pb_h", w_pb_h, mon_b.h);
                    check("busy_at_start", 160'(busy), 160'd1);
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("extra_done", 160'(done), 160'd0);
                end else begin
                    mon_h = exp_done_q.pop_front();
                    check("h_at_done", w_h, mon_h);
                end
            end
        end
    end

    task automatic exp_block(input logic [159:0] c);
        blk_t b;
        b.c = c;
        b.h = m_h;
        exp_blk_q.push_back(b);
        m_h = poly_step(m_h, c, R_KEY);
    endtask

    task automatic exp_done();
        exp_done_q.push_back(m_h);
    endtask

    task automatic idle();
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask

    // garbage on the bus while valid is low must be ignored
    task automatic gap(input int n);
        bus.msg_valid = 1'b0;
        bus.msg_data  = 32'hdeadbeef;
        bus.msg_last  = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // called just after a negedge; returns at the negedge after acceptance
    task automatic send_word(input logic [31:0] d, input logic last,
                             input logic [2:0] len);
        int t = 0;
        bus.msg_valid    = 1'b1;
        bus.msg_data     = d;
        bus.msg_last     = last;
        bus.msg_last_len = len;
        while (!bus.msg_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.msg_ready) check("accept_timeout", 160'(bus.msg_ready), 160'd1);
        @(negedge clk);
    endtask

    task automatic send_msg(input logic [2:0] len);
        for (int i = 0; i < words.size(); i++) begin
            if (i == words.size() - 1) send_word(words[i], 1'b1, len);
            else send_word(words[i], 1'b0, 3'd0);
        end
        idle();
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_blk_q.size() != 0 || exp_done_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain"}, 160'(exp_blk_q.size() + exp_done_q.size()), 160'd0);
        repeat (12) @(negedge clk);
    endtask

    task automatic do_init();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        m_h  = '0;
        check("init_clear", w_h, 160'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n          = 1'b0;
        init             = 1'b0;
        bus.msg_valid    = 1'b0;
        bus.msg_data     = 32'h0;
        bus.msg_last     = 1'b0;
        bus.msg_last_len = 3'd0;
        m_h              = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 160'(busy), 160'd0);
        check("rst_done", 160'(done), 160'd0);
        check("rst_ready", 160'(bus.msg_ready), 160'd0);
        check("rst_start", 160'(bus.pb_start), 160'd0);
        check("rst_h", w_h, 160'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 3 bytes
        do_init();
        exp_block(mk(0, 0, 0, 0, 32'h01434241));
        exp_done();
        words = '{32'h00434241};
        send_msg(3'd3);
        wait_idle("t1");

        // exactly 16 bytes: one block, no pad block
        do_init();
        exp_block(mk(1, 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100));
        exp_done();
        words = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c};
        send_msg(3'd4);
        wait_idle("t2");

        // 17 bytes, upper bytes of last word are junk
        do_init();
        exp_block(mk(1, 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100));
        exp_block(mk(0, 0, 0, 0, 32'h00000110));
        exp_done();
        words = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                  32'haabbcc10};
        send_msg(3'd1);
        wait_idle("t3");

        // RFC 8439 2.5.2
        do_init();
        exp_block(mk(1, 32'h6f462063, 32'h69687061, 32'h72676f74, 32'h70797243));
        exp_block(mk(1, 32'h6f724720, 32'h68637261, 32'h65736552, 32'h206d7572));
        exp_block(mk(0, 0, 0, 0, 32'h00017075));
        exp_done();
        words = '{32'h70797243, 32'h72676f74, 32'h69687061, 32'h6f462063,
                  32'h206d7572, 32'h65736552, 32'h68637261, 32'h6f724720,
                  32'h00007075};
        send_msg(3'd2);
        wait_idle("t4");
        check("rfc_tag", 160'(128'(w_h[127:0] + S_KEY)), 160'(TAG));

        // 20 bytes with gaps; init pulsed in WAIT and mid-COLLECT
        do_init();
        exp_block(mk(1, 32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100));
        exp_block(mk(0, 0, 0, 32'h00000001, 32'h04030201));
        exp_done();
        send_word(32'h33221100, 1'b0, 3'd0);
        gap(1);
        send_word(32'h77665544, 1'b0, 3'd0);
        gap(2);
        send_word(32'hbbaa9988, 1'b0, 3'd0);
        gap(3);
        send_word(32'hffeeddcc, 1'b0, 3'd0);
        gap(1);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        gap(6);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("t5_h_after_init", w_h, exp_blk_q.size() > 0 ? exp_blk_q[0].h : 160'd0);
        send_word(32'h04030201, 1'b1, 3'd4);
        idle();
        wait_idle("t5");

        // reset during WAIT; h is nonzero from the previous message
        exp_block(mk(1, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111));
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_msg(3'd4);
        t = 0;
        while (!bus.pb_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t6_start_seen", 160'(bus.pb_start), 160'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_busy", 160'(busy), 160'd0);
        check("t6_h", w_h, 160'd0);
        check("t6_ready", 160'(bus.msg_ready), 160'd0);
        check("t6_done", 160'(done), 160'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_h     = '0;
        @(negedge clk);
        exp_block(mk(0, 0, 0, 0, 32'h01636261));
        exp_done();
        words = '{32'h00636261};
        send_msg(3'd3);
        wait_idle("t6b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
